apb_req_arbiter: RTL
====================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REQ, 2, number of requesters sharing the APB master port.
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- ADDR_WIDTH, 32, PADDR width.
- NO_SLAVES, 4, PSEL fan-out.
- MAX_WAIT, 8, ACCESS cycles allowed with PREADY low.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK, in, 1, sole clock, rising edge.
- PRESETn, in, 1, reset, synchronous, active-low.
- req_i, in, NUM_REQ, per-requester transfer request.
- req_addr_i, in, NUM_REQ*ADDR_WIDTH, packed addresses; requester k at slice k.
- req_write_i, in, NUM_REQ, 1 = write.
- req_wdata_i, in, NUM_REQ*DATA_WIDTH, packed write data.
- done_o, out, NUM_REQ, one-cycle completion pulse to the granted requester.
- rsp_rdata_o, out, DATA_WIDTH, read data for the last completed read.
- rsp_err_o, out, 1, error status of the last completion.
- rsp_timeout_o, out, 1, last completion was a timeout.
- PSEL, out, NO_SLAVES, one-hot slave select.
- PENABLE, out, 1, APB enable.
- PADDR, out, ADDR_WIDTH, APB address.
- PWRITE, out, 1, APB direction.
- PWDATA, out, DATA_WIDTH, APB write data.
- PREADY, in, 1, slave ready.
- PRDATA, in, DATA_WIDTH, slave read data.
- PSLVERR, in, 1, slave error.
- state_o, out, 3, current FSM state.

Function
REQ-003 FSM SHALL use the one-hot State encoding IDLE=001, SETUP=010, ACCESS=100.
REQ-004 In IDLE with any req_i high, the block SHALL grant one requester round-robin, searching from (last_grant+1) mod NUM_REQ.
- It SHALL latch that requester's addr, write and wdata into PADDR/PWRITE/PWDATA.
- It SHALL move to SETUP.
REQ-005 In IDLE with no request, all PSEL SHALL be 0 and PENABLE SHALL be 0.
REQ-006 SETUP SHALL drive PSEL[PADDR[ADDR_WIDTH-1 -: log2(NO_SLAVES)]]=1 with PENABLE=0, and move unconditionally to ACCESS on the next edge.
REQ-007 ACCESS SHALL hold PSEL and set PENABLE=1.
- PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the end of ACCESS.
REQ-008 In ACCESS with PREADY=1, the block SHALL return to IDLE on that edge.
- done_o[grant] SHALL pulse for exactly one cycle.
- rsp_err_o SHALL take PSLVERR; rsp_timeout_o SHALL be 0.
- rsp_rdata_o SHALL take PRDATA on reads and be left unchanged on writes.
REQ-009 The wait counter SHALL clear on SETUP entry and increment on each ACCESS cycle with PREADY=0.
- When the count reaches MAX_WAIT, the block SHALL go to IDLE and pulse done_o[grant].
- In that case rsp_err_o SHALL be 1 and rsp_timeout_o SHALL be 1.
REQ-010 Latency with zero wait states: req_i high in IDLE at edge 0 gives SETUP after edge 1, ACCESS after edge 2, and done_o high after edge 3.
REQ-011 After every completion the block SHALL spend at least one cycle in IDLE before the next SETUP.
REQ-012 A requester dropping req_i mid-transfer SHALL NOT abort the transfer; done_o is still pulsed.
REQ-013 req_i still high in the cycle done_o is high SHALL be treated as a new request.
REQ-014 Simultaneous requests SHALL be served alternately, with no requester starved.
REQ-015 PSLVERR and PRDATA SHALL be ignored outside ACCESS with PREADY=1.

Reset
REQ-016 PRESETn=0 at a rising edge, in any state, SHALL force the following:
- state IDLE.
- PSEL, PENABLE, PWRITE, done_o, rsp_err_o and rsp_timeout_o all 0.
- PADDR, PWDATA and rsp_rdata_o all 0.
- wait counter 0; last_grant = NUM_REQ-1, so requester 0 wins first.
REQ-017 A reset during SETUP or ACCESS SHALL produce no done_o pulse for the aborted transfer.

Structure
REQ-018 shared_pkg SHALL hold:
- the State enum.
- DATA_WIDTH, ADDR_WIDTH and NO_SLAVES.
- MAX_WAIT_PEROPD, used as the MAX_WAIT default.
- a new NO_REQUESTERS=2 constant.
REQ-019 Round-robin selection SHALL live in one sub-module, apb_rr_arbiter, with inputs req and last_grant and outputs grant_valid and grant_idx.
- The FSM, counter and APB outputs SHALL live in apb_req_arbiter.

Verification
REQ-020 Single write, zero wait: req_i=01, addr=0x4000_0010, wdata=0xDEAD_BEEF, PREADY=1.
- Required: PSEL=0010 with PENABLE 0 then 1, then done_o=01 for 1 cycle and rsp_err_o=0.
REQ-021 Read with 3 wait states: req_i=10, addr=0xC000_0000, PREADY high on the 4th ACCESS cycle, PRDATA=0x1234_5678.
- Required: PSEL=1000, done_o=10 and rsp_rdata_o=0x1234_5678.
REQ-022 Contention: req_i=11 held for 4 transfers.
- Required: grant order 0,1,0,1, one done_o pulse per transfer, and at least one IDLE cycle between transfers.
REQ-023 Timeout: PREADY held 0.
- Required: exactly 8 ACCESS cycles, then done_o pulse with rsp_err_o=1 and rsp_timeout_o=1, and state_o=IDLE.
REQ-024 Slave error: PSLVERR=1 with PREADY=1 on a write.
- Required: rsp_err_o=1 and rsp_timeout_o=0.
REQ-025 Reset in ACCESS: PRESETn=0 for 1 cycle while state_o=100.
- Required: next cycle state_o=001, PSEL=0, PENABLE=0, and no done_o pulse.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types and constants for the APB request arbiter.
// The state encoding is one-hot and visible on state_o.
package shared_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } state_t;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned NO_SLAVES       = 4;
  localparam int unsigned MAX_WAIT_PEROPD = 8;
  localparam int unsigned NO_REQUESTERS   = 2;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past last_grant
// and wraps, so the most recently served requester has the lowest priority.
module apb_rr_arbiter
  import shared_pkg::*;
#(
  parameter int unsigned NUM_REQ = NO_REQUESTERS,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [31:0]      w_cand;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_cand      = '0;
    w_idx       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = (32'(last_grant) + i) % NUM_REQ;
      w_idx  = w_cand[IDX_W-1:0];
      if (!grant_valid && req[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// wait-state timeout and a registered per-requester completion pulse.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ    = shared_pkg::NO_REQUESTERS,
  parameter int unsigned DATA_WIDTH = shared_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = shared_pkg::ADDR_WIDTH,
  parameter int unsigned NO_SLAVES  = shared_pkg::NO_SLAVES,
  parameter int unsigned MAX_WAIT   = shared_pkg::MAX_WAIT_PEROPD
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          rsp_timeout_o,
  output logic [NO_SLAVES-1:0]          PSEL,
  output logic                          PENABLE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic                          PREADY,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PSLVERR,
  output logic [2:0]                    state_o
);
  import shared_pkg::*;

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SEL_W  = (NO_SLAVES > 1) ? $clog2(NO_SLAVES) : 1;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_last_grant;
  logic [WAIT_W-1:0]   r_wait;

  logic                  w_grant_valid;
  logic [IDX_W-1:0]      w_grant_idx;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_write;
  logic [NO_SLAVES-1:0]  w_psel;
  logic [WAIT_W-1:0]     w_wait_inc;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (req_i),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // Slave select is decoded from the top address bits of the winning request.
  always_comb begin
    w_addr  = req_addr_i[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    w_wdata = req_wdata_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    w_write = req_write_i[w_grant_idx];
    w_psel  = '0;
    w_psel[w_addr[ADDR_WIDTH-1 -: SEL_W]] = 1'b1;
  end

  assign w_wait_inc = r_wait + WAIT_W'(1);
  assign state_o    = r_state;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_last_grant  <= IDX_W'(NUM_REQ - 1);
      r_wait        <= '0;
      done_o        <= '0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      PSEL          <= '0;
      PENABLE       <= 1'b0;
      PADDR         <= '0;
      PWRITE        <= 1'b0;
      PWDATA        <= '0;
    end else begin
      done_o <= '0;
      unique case (r_state)
        IDLE: begin
          PSEL    <= '0;
          PENABLE <= 1'b0;
          if (w_grant_valid) begin
            r_grant      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            PADDR        <= w_addr;
            PWRITE       <= w_write;
            PWDATA       <= w_wdata;
            PSEL         <= w_psel;
            r_wait       <= '0;
            r_state      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            done_o[r_grant] <= 1'b1;
            rsp_err_o       <= PSLVERR;
            rsp_timeout_o   <= 1'b0;
            if (!PWRITE) rsp_rdata_o <= PRDATA;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            r_state <= IDLE;
          end else if (w_wait_inc == WAIT_W'(MAX_WAIT)) begin
            done_o[r_grant] <= 1'b1;
            rsp_err_o       <= 1'b1;
            rsp_timeout_o   <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        default: begin
          PSEL    <= '0;
          PENABLE <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
